// File: rtl/sram_port_arbiter.sv
// Purpose : shares one 64-bit single-port SRAM between the fetch port and the data port.
// Latency : grant is combinational; inst/data responses arrive exactly one cycle after grant.
// Backpress: the losing requester sees addr_ok=0 / stall=1 and must hold; fetch wins after STARVE_LIMIT denials.
//
// Ports:
//   clk, rst                         core clock, synchronous active-high reset
//   inst_req/inst_addr               fetch request (64-bit dual-instruction word)
//   inst_addr_ok/inst_data_ok/rdata  fetch grant, response valid, response data
//   i_stall                          fetch requested but not granted this cycle
//   data_req/wen/addr/wdata          32-bit load/store request (wen==0 means load)
//   data_addr_ok/data_data_ok/rdata  data grant, response/write-ack valid, load data
//   d_stall                          data requested but not granted this cycle
//   mem_en/wen/addr/wdata/rdata      SRAM side; rdata valid the cycle after mem_en
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [63:0] inst_rdata,
    output logic        i_stall,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        d_stall,
    output logic        mem_en,
    output logic [7:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    resp_owner_t resp_owner;
    logic        resp_lane;
    logic        grant_inst;
    logic        grant_data;
    logic        fetch_prio;

    // Address bits below the SRAM word (fetch) or below the lane (data) carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[2:0], data_addr[1:0]};

    // Data normally wins; fetch only jumps ahead once it has been denied STARVE_LIMIT times in a row.
    always_comb begin
        fetch_prio = (starve_cnt == LIMIT);
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!rst) begin
            if (data_req && !(inst_req && fetch_prio)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign i_stall      = inst_req & ~grant_inst;
    assign d_stall      = data_req & ~grant_data;

    // SRAM drive; when idle the address/data simply follow the data port.
    always_comb begin
        mem_en    = grant_inst | grant_data;
        mem_wen   = 8'h00;
        mem_addr  = {data_addr[31:3], 3'b000};
        mem_wdata = {data_wdata, data_wdata};
        if (grant_inst) begin
            mem_addr = {inst_addr[31:3], 3'b000};
        end else if (grant_data) begin
            mem_wen = data_addr[2] ? {data_wen, 4'b0000} : {4'b0000, data_wen};
        end
    end

    // Counts consecutive cycles in which fetch was waiting while data took the SRAM.
    always_ff @(posedge clk) begin
        if (rst || grant_inst || !inst_req) begin
            starve_cnt <= 4'd0;
        end else if (grant_data && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Remember who owns the SRAM read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner <= RESP_NONE;
            resp_lane  <= 1'b0;
        end else begin
            if (grant_inst) begin
                resp_owner <= RESP_INST;
            end else if (grant_data) begin
                resp_owner <= RESP_DATA;
            end else begin
                resp_owner <= RESP_NONE;
            end
            resp_lane <= data_addr[2];
        end
    end

    // rst gating drops a response whose grant happened the cycle before reset.
    always_comb begin
        inst_data_ok = !rst && (resp_owner == RESP_INST);
        data_data_ok = !rst && (resp_owner == RESP_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 64'd0;
        data_rdata   = 32'd0;
        if (data_data_ok) begin
            data_rdata = resp_lane ? mem_rdata[63:32] : mem_rdata[31:0];
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose : directed self-checking bench for sram_port_arbiter with a behavioural 64-bit SRAM.
// Latency : checks combinational grants in the driving cycle and responses one cycle later.
// Backpress: exercises contention/starvation, reset mid-access and same-cycle ok/new request.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        mem_en;
    logic [7:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // Behavioural SRAM with a bench-only preload port.
    logic [63:0] mem [0:4095];
    logic        pl_en  = 1'b0;
    logic [11:0] pl_idx = 12'd0;
    logic [63:0] pl_dat = 64'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_dat;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[14:3]];
            for (int b = 0; b < 8; b++) begin
                if (mem_wen[b]) mem[mem_addr[14:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    sram_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .i_stall(i_stall),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W2 = 64'h1111_2222_3333_4444;

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [63:0] dat);
        pl_en  = 1'b1;
        pl_idx = addr[14:3];
        pl_dat = dat;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_wen   = 4'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
    endtask

    task automatic test_reset();
        logic [4:0] vec;
        tick();
        rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h1000;
        data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h4004;
        #1;
        vec = {inst_addr_ok, data_addr_ok, i_stall, d_stall, mem_en};
        total++; if (vec !== 5'b00110) begin bad++; $display("FAIL reset_grants got %b want 00110", vec); end
        total++; if (mem_wen !== 8'h00) begin bad++; $display("FAIL reset_mem_wen got %h want 00", mem_wen); end
        tick();
        total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL reset_oks got %b want 00", {inst_data_ok, data_data_ok}); end
        total++; if (inst_rdata !== 64'd0) begin bad++; $display("FAIL reset_inst_rdata got %h want 0", inst_rdata); end
        total++; if (data_rdata !== 32'd0) begin bad++; $display("FAIL reset_data_rdata got %h want 0", data_rdata); end
        idle_inputs();
        rst = 1'b0;
        #1;
        total++; if ({inst_data_ok, data_data_ok, mem_en} !== 3'b000) begin bad++; $display("FAIL reset_release got %b want 000", {inst_data_ok, data_data_ok, mem_en}); end
    endtask

    task automatic test_fetch_only();
        logic [31:0] fa [0:2];
        logic [63:0] fw [0:2];
        logic [4:0]  vec;
        fa[0] = 32'h1000; fa[1] = 32'h1008; fa[2] = 32'h1013;
        fw[0] = W0;       fw[1] = W1;       fw[2] = W2;
        for (int i = 0; i < 5; i++) begin
            tick();
            inst_req  = (i < 3);
            inst_addr = (i < 3) ? fa[i] : 32'd0;
            #1;
            vec = {inst_addr_ok, data_addr_ok, i_stall, d_stall, mem_en};
            total++; if (vec !== ((i < 3) ? 5'b10001 : 5'b00000)) begin bad++; $display("FAIL fetch_grant[%0d] got %b", i, vec); end
            if (i < 3) begin
                total++; if (mem_addr !== {fa[i][31:3], 3'b000} || mem_wen !== 8'h00) begin bad++; $display("FAIL fetch_mem[%0d] got addr=%h wen=%h want addr=%h wen=00", i, mem_addr, mem_wen, {fa[i][31:3], 3'b000}); end
            end
            total++; if (inst_data_ok !== (i >= 1 && i <= 3)) begin bad++; $display("FAIL fetch_ok[%0d] got %b", i, inst_data_ok); end
            if (i >= 1 && i <= 3) begin
                total++; if (inst_rdata !== fw[i-1]) begin bad++; $display("FAIL fetch_rdata[%0d] got %h want %h", i, inst_rdata, fw[i-1]); end
            end
        end
    endtask

    task automatic test_load_lane();
        tick();
        data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h2004;
        #1;
        total++; if ({data_addr_ok, d_stall, mem_en} !== 3'b101) begin bad++; $display("FAIL load_grant got %b want 101", {data_addr_ok, d_stall, mem_en}); end
        total++; if (mem_addr !== 32'h2000 || mem_wen !== 8'h00) begin bad++; $display("FAIL load_mem got addr=%h wen=%h want 2000/00", mem_addr, mem_wen); end
        tick();
        data_addr = 32'h2000;
        #1;
        total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hAAAA_BBBB) begin bad++; $display("FAIL load_hi got ok=%b rdata=%h want 1/aaaabbbb", data_data_ok, data_rdata); end
        tick();
        data_req = 1'b0;
        #1;
        total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hCCCC_DDDD) begin bad++; $display("FAIL load_lo got ok=%b rdata=%h want 1/ccccdddd", data_data_ok, data_rdata); end
        tick();
        total++; if (data_data_ok !== 1'b0 || data_rdata !== 32'd0) begin bad++; $display("FAIL load_idle got ok=%b rdata=%h want 0/0", data_data_ok, data_rdata); end
    endtask

    task automatic test_store_byte();
        tick();
        data_req = 1'b1; data_wen = 4'b0010; data_addr = 32'h3004; data_wdata = 32'h0000_5A00;
        #1;
        total++; if (data_addr_ok !== 1'b1 || mem_wen !== 8'b0010_0000) begin bad++; $display("FAIL store_wen got ok=%b wen=%b want 1/00100000", data_addr_ok, mem_wen); end
        total++; if (mem_wdata !== 64'h00005A00_00005A00 || mem_addr !== 32'h3000) begin bad++; $display("FAIL store_bus got wdata=%h addr=%h", mem_wdata, mem_addr); end
        tick();
        data_wen = 4'd0; data_wdata = 32'd0;
        #1;
        total++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1) begin bad++; $display("FAIL store_ack got ok=%b grant=%b want 1/1", data_data_ok, data_addr_ok); end
        tick();
        data_addr = 32'h3000;
        #1;
        total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h1122_5A44) begin bad++; $display("FAIL store_readback_hi got ok=%b rdata=%h want 1/11225a44", data_data_ok, data_rdata); end
        tick();
        data_req = 1'b0;
        #1;
        total++; if (data_rdata !== 32'h5566_7788) begin bad++; $display("FAIL store_readback_lo got %h want 55667788", data_rdata); end
    endtask

    task automatic test_contention();
        logic [4:0] vec;
        logic       exp_d;
        logic       prev_d;
        prev_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            inst_req = 1'b1; inst_addr = 32'h1000;
            data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h4000; data_wdata = 32'hDEAD_BEEF;
            #1;
            exp_d = (i % 4) != 3;
            vec = {inst_addr_ok, data_addr_ok, i_stall, d_stall, mem_en};
            total++; if (vec !== (exp_d ? 5'b01101 : 5'b10011)) begin bad++; $display("FAIL contend_grant[%0d] got %b want %b", i, vec, exp_d ? 5'b01101 : 5'b10011); end
            total++; if (mem_wen !== (exp_d ? 8'h0F : 8'h00) || mem_addr !== (exp_d ? 32'h4000 : 32'h1000)) begin bad++; $display("FAIL contend_mem[%0d] got wen=%h addr=%h", i, mem_wen, mem_addr); end
            if (i > 0) begin
                total++; if ({inst_data_ok, data_data_ok} !== (prev_d ? 2'b01 : 2'b10)) begin bad++; $display("FAIL contend_ok[%0d] got %b", i, {inst_data_ok, data_data_ok}); end
            end
            prev_d = exp_d;
        end
        tick();
        idle_inputs();
        #1;
        total++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin bad++; $display("FAIL contend_last_ok got %b want 10", {inst_data_ok, data_data_ok}); end
    endtask

    task automatic test_reset_midop();
        tick();
        data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h2004;
        #1;
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL midop_grant got %b want 1", data_addr_ok); end
        tick();
        rst = 1'b1; data_req = 1'b0;
        #1;
        total++; if (data_data_ok !== 1'b0 || data_rdata !== 32'd0 || inst_data_ok !== 1'b0) begin bad++; $display("FAIL midop_rst_cycle got dok=%b rdata=%h iok=%b", data_data_ok, data_rdata, inst_data_ok); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (data_data_ok !== 1'b0 || data_rdata !== 32'd0) begin bad++; $display("FAIL midop_after_rst got ok=%b rdata=%h want 0/0", data_data_ok, data_rdata); end
        tick();
        data_req = 1'b1; data_addr = 32'h2004;
        #1;
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL midop_regrant got %b want 1", data_addr_ok); end
        tick();
        data_req = 1'b0;
        #1;
        total++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hAAAA_BBBB) begin bad++; $display("FAIL midop_resume got ok=%b rdata=%h want 1/aaaabbbb", data_data_ok, data_rdata); end
    endtask

    task automatic test_reset_starve();
        // Build the starvation count to its limit, reset, then contend again: data must win first.
        for (int i = 0; i < 3; i++) begin
            tick();
            inst_req = 1'b1; inst_addr = 32'h1000;
            data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h2000;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin bad++; $display("FAIL starve_cleared got %b want 01", {inst_addr_ok, data_addr_ok}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        tick();
        inst_req = 1'b1; inst_addr = 32'h1000;
        #1;
        total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL b2b_first_grant got %b want 1", inst_addr_ok); end
        tick();
        inst_addr = 32'h1008;
        #1;
        total++; if ({inst_addr_ok, inst_data_ok} !== 2'b11 || inst_rdata !== W0) begin bad++; $display("FAIL b2b_overlap got grant/ok=%b rdata=%h want 11/%h", {inst_addr_ok, inst_data_ok}, inst_rdata, W0); end
        tick();
        inst_req = 1'b0;
        #1;
        total++; if ({inst_addr_ok, inst_data_ok} !== 2'b01 || inst_rdata !== W1) begin bad++; $display("FAIL b2b_second got grant/ok=%b rdata=%h want 01/%h", {inst_addr_ok, inst_data_ok}, inst_rdata, W1); end
        tick();
        total++; if (inst_data_ok !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got %b want 0", inst_data_ok); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        preload(32'h1000, W0);
        preload(32'h1008, W1);
        preload(32'h1010, W2);
        preload(32'h2000, 64'hAAAA_BBBB_CCCC_DDDD);
        preload(32'h3000, 64'h1122_3344_5566_7788);
        test_reset();
        test_fetch_only();
        test_load_lane();
        test_store_byte();
        test_contention();
        test_reset_midop();
        test_reset_starve();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 64-bit single-port synchronous SRAM between the instruction-fetch port (64-bit dual-instruction fetch) and the data port (32-bit load/store).
- Arbitrates each cycle with data-first priority and a starvation guard for fetch.
- Drives the i_stall/d_stall signals the datapath currently ties to 0.
- Sits between the datapath/fetch splitter and the memory.

Parameters:
- STARVE_LIMIT, 3, consecutive denied fetch cycles after which fetch takes priority for one grant (legal range 1..15).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active high.
- inst_req  in  1  fetch request; held with inst_addr stable until inst_addr_ok.
- inst_addr  in  32  fetch address; bits [2:0] ignored.
- inst_addr_ok  out  1  fetch granted this cycle (combinational).
- inst_data_ok  out  1  fetch response valid (one cycle after grant).
- inst_rdata  out  64  fetch data, valid with inst_data_ok.
- i_stall  out  1  inst_req & ~inst_addr_ok.
- data_req  in  1  data request; held with addr/wen/wdata stable until data_addr_ok.
- data_wen  in  4  byte enables; 0 = read.
- data_addr  in  32  byte address; bit [2] selects the 32-bit lane.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data granted this cycle (combinational).
- data_data_ok  out  1  data response or write ack (one cycle after grant).
- data_rdata  out  32  load data, valid with data_data_ok.
- d_stall  out  1  data_req & ~data_addr_ok.
- mem_en  out  1  SRAM enable.
- mem_wen  out  8  SRAM byte write enables.
- mem_addr  out  32  SRAM address, always {addr[31:3],3'b000}.
- mem_wdata  out  64  SRAM write data.
- mem_rdata  in  64  SRAM read data, valid the cycle after mem_en.

Behaviour:
Grant logic (combinational):
- While rst=1, all grants, mem_en and mem_wen are 0.
- At most one grant per cycle.
- Default priority: data wins.
- Fetch wins instead when starve_cnt == STARVE_LIMIT and both ports request.
- Single requester: granted every cycle, so back-to-back issue gives 1 access/cycle.

Memory side:
- mem_en = grant_inst | grant_data.
- On an inst grant: mem_wen = 0 and mem_addr comes from inst_addr.
- On a data grant: mem_addr comes from data_addr.
  - mem_wen = addr[2] ? {data_wen,4'b0} : {4'b0,data_wen}.
  - mem_wdata = {data_wdata,data_wdata}.
- With no grant: mem_wen = 0, and mem_addr/mem_wdata are don't-care.

Starvation counter (4-bit register):
- Cleared on rst, on an inst grant, or when inst_req=0.
- Incremented when inst_req=1 and data is granted.
- Saturates at STARVE_LIMIT.

Response pipeline (registered, 1-cycle latency):
- resp_owner ∈ {NONE, INST, DATA} and resp_lane are captured at grant.
- Next cycle:
  - INST: inst_data_ok=1, inst_rdata=mem_rdata.
  - DATA: data_data_ok=1, data_rdata = resp_lane ? mem_rdata[63:32] : mem_rdata[31:0].
  - Writes also produce data_data_ok; data_rdata is don't-care for writes.
- Otherwise the ok outputs are 0.

Reset and boundary conditions:
- Reset values: inst_data_ok=0, data_data_ok=0, inst_rdata=0, data_rdata=0, starve_cnt=0, resp_owner=NONE.
- Reset mid-transaction: an access granted in the cycle before rst gets no ok in the rst cycle or after it; the response is dropped.
- A requester may issue its next request in the same cycle its previous data_ok arrives. That request is arbitrated normally.
- Requests dropped before grant are legal and leave no state behind.

Test Plan:
- Fetch only: inst_req=1 for addrs 0x1000, 0x1008, 0x1010 on consecutive grants, mem preloaded → inst_addr_ok every cycle; inst_data_ok 1 cycle later with matching 64-bit words; i_stall=0 throughout.
- Load lane select: data read at 0x2004 with mem[0x2000]=0xAAAA_BBBB_CCCC_DDDD → mem_addr=0x2000, mem_wen=0; next cycle data_rdata=0xAAAA_BBBB, data_data_ok=1.
- Store byte: data_wen=4'b0010, addr=0x3004, wdata=0x0000_5A00 → mem_wen=8'b0010_0000, mem_wdata=0x00005A00_00005A00; data_data_ok next cycle; readback of 0x3004 returns byte 1 = 0x5A.
- Contention, STARVE_LIMIT=3: both requesting continuously → grants D,D,D,I,D,D,D,I…; i_stall high exactly on the 3 denied cycles.
- Reset mid-op: grant a data load at cycle t, assert rst at t+1 → data_data_ok=0 at t+1 and t+2; all outputs at reset values; the first grant after deassert completes normally.
- Same-cycle ok/new request: fetch granted at t, new inst_addr presented at t+1 → inst_data_ok and inst_addr_ok both 1 at t+1; no duplicate response.
